call_scheduler: RTL and testbench

- Latches car (cab) calls and hall up/down calls into pending vectors.
- Tracks a travel direction using LOOK scheduling.
- Produces the stop mask and above/below summaries that drive the elevator FSM controller. It sits between the button/input logic and the FSM controller.
- Pending calls are retired when the controller pulses clear_current_request.

---
 rtl/call_scheduler_if.sv | 45 ++++
 rtl/call_scheduler.sv | 161 ++++++++++++++++
 tb/tb_call_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/call_scheduler_if.sv
// Call-scheduler bus: button strobes and car status in, stop mask and summaries out.
// master = button/controller side, slave = scheduler.
interface call_scheduler_if #(
    parameter int NUM_FLOORS  = 10,
    parameter int FLOOR_WIDTH = 4
);
    logic                   cab_call_valid;
    logic [FLOOR_WIDTH-1:0] cab_call_floor;
    logic                   hall_up_valid;
    logic [FLOOR_WIDTH-1:0] hall_up_floor;
    logic                   hall_down_valid;
    logic [FLOOR_WIDTH-1:0] hall_down_floor;
    logic [FLOOR_WIDTH-1:0] current_floor;
    logic                   moving_up;
    logic                   moving_down;
    logic                   clear_current_request;
    logic [NUM_FLOORS-1:0]  floor_requests;
    logic                   has_request_above;
    logic                   has_request_below;
    logic [1:0]             sched_dir;
    logic [FLOOR_WIDTH:0]   pending_count;
    logic                   req_error;

    modport master (
        output cab_call_valid, cab_call_floor,
        output hall_up_valid, hall_up_floor,
        output hall_down_valid, hall_down_floor,
        output current_floor, moving_up, moving_down,
        output clear_current_request,
        input  floor_requests, has_request_above,
        input  has_request_below, sched_dir,
        input  pending_count, req_error
    );

    modport slave (
        input  cab_call_valid, cab_call_floor,
        input  hall_up_valid, hall_up_floor,
        input  hall_down_valid, hall_down_floor,
        input  current_floor, moving_up, moving_down,
        input  clear_current_request,
        output floor_requests, has_request_above,
        output has_request_below, sched_dir,
        output pending_count, req_error
    );
endinterface

// File: rtl/call_scheduler.sv
// LOOK call scheduler: latches cab/hall calls, tracks direction, builds stop mask.
// Optional fire recall behind `define SCHED_FIRE_RECALL_EN.
module call_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_WIDTH  = 4,
    parameter int RECALL_FLOOR = 0
) (
    input logic clk,
    input logic reset,
`ifdef SCHED_FIRE_RECALL_EN
    input logic fire_recall,
`endif
    call_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_UP   = 2'b01,
        D_DOWN = 2'b10
    } dir_e;

    localparam logic [FLOOR_WIDTH:0] NF =
        (FLOOR_WIDTH+1)'(NUM_FLOORS);
    localparam logic [FLOOR_WIDTH:0] NF_M1 =
        (FLOOR_WIDTH+1)'(NUM_FLOORS-1);
    localparam logic [NUM_FLOORS-1:0] ONE =
        NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] cab_q, cab_d;
    logic [NUM_FLOORS-1:0] up_q, up_d;
    logic [NUM_FLOORS-1:0] dn_q, dn_d;
    dir_e                  dir_q, dir_d;
    logic                  err_q, err_d;

    logic                  fire;
    logic [NUM_FLOORS-1:0] any_pend, view, recall_oh;
    logic [NUM_FLOORS-1:0] none_above, none_below;
    logic [NUM_FLOORS-1:0] up_inc, dn_inc, stop, cur_oh;
    logic [NUM_FLOORS-1:0] set_cab, set_up, set_dn;
    logic [NUM_FLOORS-1:0] clr_cab, clr_up, clr_dn;
    logic                  cur_ok, cab_ok, up_ok, dn_ok;
    logic                  above, below, acc_a, acc_b, clr;
    logic [FLOOR_WIDTH:0]  cnt;
    int                    cur_i;

`ifdef SCHED_FIRE_RECALL_EN
    assign fire = fire_recall;
`else
    assign fire = 1'b0;
`endif

    assign cur_i  = int'(bus.current_floor);
    assign cur_ok = {1'b0, bus.current_floor} < NF;
    assign cab_ok = {1'b0, bus.cab_call_floor} < NF;
    assign up_ok  = {1'b0, bus.hall_up_floor} < NF_M1;
    assign dn_ok  = ({1'b0, bus.hall_down_floor} < NF) &&
                    (bus.hall_down_floor != '0);

    assign any_pend = cab_q | up_q | dn_q;

    always_comb begin
        recall_oh = '0;
        recall_oh[RECALL_FLOOR] = 1'b1;
        view = fire ? recall_oh : any_pend;
    end

    // none_above[f]/none_below[f]: no call of any type strictly beyond f
    always_comb begin
        acc_a = 1'b0;
        acc_b = 1'b0;
        none_above = '0;
        none_below = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            none_above[f] = ~acc_a;
            acc_a = acc_a | any_pend[f];
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            none_below[f] = ~acc_b;
            acc_b = acc_b | any_pend[f];
        end
    end

    always_comb begin
        cur_oh = '0;
        above  = 1'b0;
        below  = 1'b0;
        cnt    = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (cur_ok && f == cur_i) cur_oh[f] = 1'b1;
            if (cur_ok && f > cur_i) above = above | view[f];
            if (!cur_ok || f < cur_i) below = below | view[f];
            cnt = cnt + {{FLOOR_WIDTH{1'b0}}, any_pend[f]};
        end
    end

    assign up_inc = (dir_q == D_DOWN) ? none_below : '1;
    assign dn_inc = (dir_q == D_UP)   ? none_above : '1;
    assign stop   = fire ? recall_oh :
                    (cab_q | (up_q & up_inc) | (dn_q & dn_inc));

    // Clear masks are based on inclusion so a same-cycle press is swallowed
    always_comb begin
        clr     = bus.clear_current_request && cur_ok;
        clr_cab = clr ? cur_oh : '0;
        clr_up  = clr ? (cur_oh & up_inc) : '0;
        clr_dn  = clr ? (cur_oh & dn_inc) : '0;
        set_cab = '0;
        set_up  = '0;
        set_dn  = '0;
        if (bus.cab_call_valid && cab_ok)
            set_cab = ONE << bus.cab_call_floor;
        if (bus.hall_up_valid && up_ok)
            set_up = ONE << bus.hall_up_floor;
        if (bus.hall_down_valid && dn_ok)
            set_dn = ONE << bus.hall_down_floor;
        cab_d = fire ? '0 : ((cab_q | set_cab) & ~clr_cab);
        up_d  = fire ? '0 : ((up_q | set_up) & ~clr_up);
        dn_d  = fire ? '0 : ((dn_q | set_dn) & ~clr_dn);
        err_d = !fire &&
                ((bus.cab_call_valid && !cab_ok) ||
                 (bus.hall_up_valid && !up_ok) ||
                 (bus.hall_down_valid && !dn_ok));
    end

    always_comb begin
        dir_d = dir_q;
        if (!bus.moving_up && !bus.moving_down) begin
            unique case (dir_q)
                D_IDLE, D_UP:
                    dir_d = above ? D_UP :
                            below ? D_DOWN : D_IDLE;
                D_DOWN:
                    dir_d = below ? D_DOWN :
                            above ? D_UP : D_IDLE;
                default: dir_d = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cab_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
            dir_q <= D_IDLE;
            err_q <= 1'b0;
        end else begin
            cab_q <= cab_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
            dir_q <= dir_d;
            err_q <= err_d;
        end
    end

    assign bus.floor_requests    = stop;
    assign bus.has_request_above = above;
    assign bus.has_request_below = below;
    assign bus.sched_dir         = dir_q;
    assign bus.pending_count     = cnt;
    assign bus.req_error         = err_q;
endmodule

// File: tb/tb_call_scheduler.sv
// Random + directed bench for call_scheduler against a floor-array reference model.
// Define SCHED_FIRE_RECALL_EN to also exercise fire recall.
module tb_call_scheduler;
    localparam int NF = 10;
    localparam int FW = 4;
    localparam int RF = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_WIDTH(FW)) bus ();
`ifdef SCHED_FIRE_RECALL_EN
    logic fire_recall;
`endif

    call_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .RECALL_FLOOR(RF)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef SCHED_FIRE_RECALL_EN
        .fire_recall(fire_recall),
`endif
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    bit m_cab[NF];
    bit m_up[NF];
    bit m_dn[NF];
    int m_dir;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit fr();
`ifdef SCHED_FIRE_RECALL_EN
        return fire_recall;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit real_at(int f);
        return m_cab[f] | m_up[f] | m_dn[f];
    endfunction

    function automatic bit real_above(int f);
        for (int g = f + 1; g < NF; g++) if (real_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit real_below(int f);
        for (int g = 0; g < f && g < NF; g++) if (real_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_at(int f);
        return fr() ? (f == RF) : real_at(f);
    endfunction

    function automatic bit view_above(int c);
        if (c >= NF) return 1'b0;
        for (int g = c + 1; g < NF; g++) if (req_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit view_below(int c);
        for (int g = 0; g < NF; g++)
            if ((c >= NF || g < c) && req_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit stop_at(int f);
        if (fr()) return f == RF;
        case (m_dir)
            1: return m_cab[f] | m_up[f] | (m_dn[f] & !real_above(f));
            2: return m_cab[f] | m_dn[f] | (m_up[f] & !real_below(f));
            default: return real_at(f);
        endcase
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            m_cab[f] = 0; m_up[f] = 0; m_dn[f] = 0;
        end
        m_dir = 0;
        m_err = 0;
    endtask

    task automatic check_outputs();
        logic [NF-1:0] er;
        int c, cnt;
        c = int'(bus.current_floor);
        cnt = 0;
        er = '0;
        for (int f = 0; f < NF; f++) begin
            er[f] = stop_at(f);
            if (real_at(f)) cnt++;
        end
        chk("floor_requests", 32'(bus.floor_requests), 32'(er));
        chk("above", 32'(bus.has_request_above), 32'(view_above(c)));
        chk("below", 32'(bus.has_request_below), 32'(view_below(c)));
        chk("sched_dir", 32'(bus.sched_dir), 32'(m_dir));
        chk("pending_count", 32'(bus.pending_count), 32'(cnt));
        chk("req_error", 32'(bus.req_error), 32'(m_err));
    endtask

    task automatic model_advance();
        int c, cf, uf, df, nd;
        bit a, b, s_up, s_dn, clr;
        c  = int'(bus.current_floor);
        cf = int'(bus.cab_call_floor);
        uf = int'(bus.hall_up_floor);
        df = int'(bus.hall_down_floor);
        nd = m_dir;
        if (!bus.moving_up && !bus.moving_down) begin
            a = view_above(c);
            b = view_below(c);
            if (m_dir == 2) nd = b ? 2 : a ? 1 : 0;
            else nd = a ? 1 : b ? 2 : 0;
        end
        if (fr()) begin
            model_reset();
        end else begin
            clr  = bus.clear_current_request && c < NF;
            s_up = clr && (m_dir != 2 || !real_below(c));
            s_dn = clr && (m_dir != 1 || !real_above(c));
            m_err = (bus.cab_call_valid && cf >= NF) ||
                    (bus.hall_up_valid && uf >= NF - 1) ||
                    (bus.hall_down_valid && (df >= NF || df == 0));
            if (clr) m_cab[c] = 0;
            if (s_up) m_up[c] = 0;
            if (s_dn) m_dn[c] = 0;
            if (bus.cab_call_valid && cf < NF && !(clr && cf == c))
                m_cab[cf] = 1;
            if (bus.hall_up_valid && uf < NF - 1 && !(s_up && uf == c))
                m_up[uf] = 1;
            if (bus.hall_down_valid && df < NF && df != 0 &&
                !(s_dn && df == c))
                m_dn[df] = 1;
        end
        m_dir = nd;
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_advance();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.cab_call_valid = 0;
        bus.hall_up_valid = 0;
        bus.hall_down_valid = 0;
        bus.clear_current_request = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        quiet();
        bus.moving_up = 0;
        bus.moving_down = 0;
        @(negedge clk);
        model_reset();
        reset = 0;
    endtask

    initial begin
        bus.cab_call_floor = '0;
        bus.hall_up_floor = '0;
        bus.hall_down_floor = '0;
        bus.current_floor = '0;
`ifdef SCHED_FIRE_RECALL_EN
        fire_recall = 0;
`endif
        do_reset();
        #1;
        chk("rst_req", 32'(bus.floor_requests), 32'h0);
        chk("rst_cnt", 32'(bus.pending_count), 32'h0);
        chk("rst_dir", 32'(bus.sched_dir), 32'h0);

        bus.current_floor = 4'd2;
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd7;
        tick();
        quiet();
        #1;
        chk("t1_req", 32'(bus.floor_requests), 32'h080);
        chk("t1_above", 32'(bus.has_request_above), 32'h1);
        chk("t1_cnt", 32'(bus.pending_count), 32'h1);
        tick();
        chk("t1_dir", 32'(bus.sched_dir), 32'h1);

        bus.current_floor = 4'd3;
        bus.hall_down_valid = 1; bus.hall_down_floor = 4'd5;
        bus.hall_up_valid = 1; bus.hall_up_floor = 4'd8;
        tick();
        quiet();
        bus.current_floor = 4'd7; bus.moving_up = 1;
        bus.clear_current_request = 1;
        tick();
        quiet();
        bus.current_floor = 4'd3; bus.moving_up = 0;
        #1;
        chk("t2_req", 32'(bus.floor_requests), 32'h100);
        tick();
        bus.current_floor = 4'd8; bus.moving_up = 1;
        bus.clear_current_request = 1;
        tick();
        quiet();
        #1;
        chk("t2_req_dn", 32'(bus.floor_requests), 32'h020);
        bus.moving_up = 0;
        tick();
        chk("t2_dir", 32'(bus.sched_dir), 32'h2);

        bus.hall_up_valid = 1; bus.hall_up_floor = 4'd9;
        bus.hall_down_valid = 1; bus.hall_down_floor = 4'd0;
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd12;
        tick();
        quiet();
        #1;
        chk("t3_err", 32'(bus.req_error), 32'h1);
        chk("t3_cnt", 32'(bus.pending_count), 32'h1);
        tick();
        chk("t3_err_off", 32'(bus.req_error), 32'h0);

        #2 reset = 1;
        #1;
        chk("arst_cnt", 32'(bus.pending_count), 32'h0);
        chk("arst_dir", 32'(bus.sched_dir), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;

        bus.current_floor = 4'd4;
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd4;
        bus.hall_up_valid = 1; bus.hall_up_floor = 4'd4;
        bus.hall_down_valid = 1; bus.hall_down_floor = 4'd4;
        tick();
        quiet();
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd6;
        tick();
        quiet();
        tick();
        bus.clear_current_request = 1;
        tick();
        quiet();
        #1;
        chk("t4_cnt", 32'(bus.pending_count), 32'h2);
        chk("t4_req", 32'(bus.floor_requests), 32'h040);
        bus.clear_current_request = 1;
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd4;
        tick();
        quiet();
        #1;
        chk("t5_req", 32'(bus.floor_requests), 32'h040);
        chk("t5_cnt", 32'(bus.pending_count), 32'h2);
        bus.current_floor = 4'd6; bus.moving_up = 1;
        bus.clear_current_request = 1;
        tick();
        bus.current_floor = 4'd4;
        tick();
        quiet();
        chk("t5_hold", 32'(bus.sched_dir), 32'h1);
        chk("t5_empty", 32'(bus.pending_count), 32'h0);
        bus.moving_up = 0;
        tick();
        chk("t5_idle", 32'(bus.sched_dir), 32'h0);

`ifdef SCHED_FIRE_RECALL_EN
        do_reset();
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd2;
        tick();
        bus.cab_call_floor = 4'd8;
        tick();
        quiet();
        bus.current_floor = 4'd6;
        fire_recall = 1;
        #1;
        chk("fr_req", 32'(bus.floor_requests), 32'h001);
        chk("fr_below", 32'(bus.has_request_below), 32'h1);
        tick();
        chk("fr_cnt", 32'(bus.pending_count), 32'h0);
        bus.cab_call_valid = 1; bus.cab_call_floor = 4'd5;
        bus.hall_down_valid = 1; bus.hall_down_floor = 4'd0;
        tick();
        quiet();
        chk("fr_ign", 32'(bus.pending_count), 32'h0);
        chk("fr_noerr", 32'(bus.req_error), 32'h0);
        fire_recall = 0;
        tick();
        chk("fr_off_cnt", 32'(bus.pending_count), 32'h0);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.current_floor = ($urandom_range(0, 9) == 0) ?
                FW'($urandom_range(10, 15)) : FW'($urandom_range(0, 9));
            bus.cab_call_valid = ($urandom_range(0, 2) == 0);
            bus.hall_up_valid = ($urandom_range(0, 2) == 0);
            bus.hall_down_valid = ($urandom_range(0, 2) == 0);
            bus.cab_call_floor = FW'($urandom_range(0, 11));
            bus.hall_up_floor = FW'($urandom_range(0, 11));
            bus.hall_down_floor = FW'($urandom_range(0, 11));
            bus.clear_current_request = ($urandom_range(0, 2) == 0);
            bus.moving_up = ($urandom_range(0, 4) == 0);
            bus.moving_down = ($urandom_range(0, 4) == 0);
`ifdef SCHED_FIRE_RECALL_EN
            if ($urandom_range(0, 39) == 0) fire_recall = ~fire_recall;
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
